// File: rtl/data_bus_responder.sv
// Data-port responder: 256-word data RAM plus a register window with GPIO, a free-running
// cycle counter and a compare timer. Reads are registered (one-cycle latency, read-before-write).
module data_bus_responder #(
    parameter int RAM_WORDS = 256,
    parameter int GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write_enable,
    input  logic [31:0]       WriteAddress,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              timer_irq
);
    localparam int AW = $clog2(RAM_WORDS);

    localparam logic [29:0] WA_GPIO_OUT = 30'h0000_0400;
    localparam logic [29:0] WA_GPIO_IN  = 30'h0000_0401;
    localparam logic [29:0] WA_CYCLE    = 30'h0000_0402;
    localparam logic [29:0] WA_CMP      = 30'h0000_0403;
    localparam logic [29:0] WA_CTRL     = 30'h0000_0404;
    localparam logic [29:0] WA_CNT      = 30'h0000_0405;

    logic [31:0]       ram [RAM_WORDS];
    logic [31:0]       ram_rd_q;
    logic              sel_ram_q;
    logic [31:0]       reg_rd_q, reg_rd_d;

    logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
    logic [GPIO_W-1:0] sync1_q, sync2_q;
    logic [31:0]       cycle_q;
    logic [31:0]       cmp_q, cmp_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              en_q, en_d;
    logic              exp_q, exp_d;

    logic [AW-1:0]     ram_idx;
    logic [29:0]       word_addr;
    logic              ram_hit;
    logic              wr;
    logic              match;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^WriteAddress[1:0];
    assign word_addr = WriteAddress[31:2];
    assign ram_idx   = WriteAddress[AW+1:2];
    // Everything above the RAM index must be zero, so addresses past the RAM never alias it.
    assign ram_hit   = (WriteAddress[31:AW+2] == '0);
    assign wr        = write_enable && reset;

    always_ff @(posedge clk) begin
        if (wr && ram_hit) begin
            ram[ram_idx] <= WriteData;
        end
        ram_rd_q <= ram[ram_idx];
    end

    always_comb begin
        reg_rd_d = 32'h0;
        case (word_addr)
            WA_GPIO_OUT: reg_rd_d = {{(32-GPIO_W){1'b0}}, gpio_out_q};
            WA_GPIO_IN:  reg_rd_d = {{(32-GPIO_W){1'b0}}, sync2_q};
            WA_CYCLE:    reg_rd_d = cycle_q;
            WA_CMP:      reg_rd_d = cmp_q;
            WA_CTRL:     reg_rd_d = {30'h0, exp_q, en_q};
            WA_CNT:      reg_rd_d = cnt_q;
            default:     reg_rd_d = 32'h0;
        endcase
    end

    always_comb begin
        gpio_out_d = gpio_out_q;
        cmp_d      = cmp_q;
        cnt_d      = cnt_q;
        en_d       = en_q;
        exp_d      = exp_q;
        match      = en_q && (cnt_q == cmp_q);
        if (en_q) begin
            cnt_d = match ? 32'h0 : cnt_q + 32'd1;
        end
        if (write_enable) begin
            case (word_addr)
                WA_GPIO_OUT: gpio_out_d = WriteData[GPIO_W-1:0];
                WA_CMP:      cmp_d      = WriteData;
                WA_CNT:      cnt_d      = WriteData;
                WA_CTRL: begin
                    en_d = WriteData[0];
                    if (WriteData[1]) begin
                        exp_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        // A compare match beats a same-cycle clear of EXPIRED.
        if (match) begin
            exp_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sel_ram_q  <= 1'b0;
            reg_rd_q   <= 32'h0;
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cycle_q    <= 32'h0;
            cmp_q      <= 32'h0;
            cnt_q      <= 32'h0;
            en_q       <= 1'b0;
            exp_q      <= 1'b0;
        end else begin
            sel_ram_q  <= ram_hit;
            reg_rd_q   <= reg_rd_d;
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            cycle_q    <= cycle_q + 32'd1;
            cmp_q      <= cmp_d;
            cnt_q      <= cnt_d;
            en_q       <= en_d;
            exp_q      <= exp_d;
        end
    end

    assign ReadData  = sel_ram_q ? ram_rd_q : reg_rd_q;
    assign gpio_out  = gpio_out_q;
    assign timer_irq = exp_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed bus cycles push expected observations into a
// scoreboard queue tagged with the clock edge after which they must hold.
module tb_data_bus_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        write_enable = 1'b0;
    logic [31:0] WriteAddress = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic [31:0] ReadData;
    logic [7:0]  gpio_in = 8'h0;
    logic [7:0]  gpio_out;
    logic        timer_irq;

    data_bus_responder #(.RAM_WORDS(256), .GPIO_W(8)) dut (
        .clk(clk), .reset(reset), .write_enable(write_enable),
        .WriteAddress(WriteAddress), .WriteData(WriteData), .ReadData(ReadData),
        .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          kind;   // 0 ReadData, 1 gpio_out, 2 timer_irq
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   edge_n = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic void push(input int kind, input int delay, input logic [31:0] e, input string n);
        exp_t x;
        x.due  = edge_n + delay;
        x.kind = kind;
        x.exp  = e;
        x.name = n;
        q.push_back(x);
    endfunction

    always @(posedge clk) begin
        logic [31:0] act;
        edge_n = edge_n + 1;
        #1;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].due == edge_n) begin
                case (q[i].kind)
                    0:       act = ReadData;
                    1:       act = {24'h0, gpio_out};
                    default: act = {31'h0, timer_irq};
                endcase
                n_vec++;
                if (act !== q[i].exp) begin
                    n_bad++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", q[i].name, act, q[i].exp);
                end else begin
                    $display("ok   %s: 0x%08h", q[i].name, act);
                end
                q.delete(i);
            end
        end
    end

    task automatic drive(input logic rn, input logic we, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        reset        = rn;
        write_enable = we;
        WriteAddress = a;
        WriteData    = d;
    endtask

    initial begin
        // Reset
        drive(0, 0, 32'h8, 0);      push(0, 1, 32'h0, "rst_readdata");
        drive(0, 0, 32'h8, 0);      push(1, 1, 32'h0, "rst_gpio_out"); push(2, 1, 0, "rst_irq");

        // RAM store/load and read-before-write
        drive(1, 1, 32'h4, 32'h1234_5678);
        drive(1, 0, 32'h4, 0);      push(0, 1, 32'h1234_5678, "ram_load");
        drive(1, 1, 32'h10, 32'h5555_5555);
        drive(1, 1, 32'h10, 32'hAAAA_AAAA); push(0, 1, 32'h5555_5555, "rbw_old");
        drive(1, 0, 32'h10, 0);     push(0, 1, 32'hAAAA_AAAA, "rbw_new");

        // GPIO out and synchronized input
        drive(1, 1, 32'h1000, 32'h1A5); push(1, 2, 32'hA5, "gpio_out_pin");
        drive(1, 0, 32'h1000, 0);   push(0, 1, 32'hA5, "gpio_out_rd");
        drive(1, 0, 32'h1004, 0);
        gpio_in = 8'h3C;
        push(0, 1, 32'h0, "gpio_in_e1"); push(0, 2, 32'h0, "gpio_in_e2"); push(0, 3, 32'h3C, "gpio_in_e3");
        drive(1, 0, 32'h1004, 0);
        drive(1, 0, 32'h1004, 0);

        // Timer CMP=3, count 0..3, match edge W1C loses to set, later W1C clears
        drive(1, 1, 32'h100C, 3);
        drive(1, 1, 32'h1010, 1);
        drive(1, 0, 32'h1014, 0);   push(0, 1, 32'h0, "cnt0"); push(2, 1, 0, "irq_pre");
        drive(1, 0, 32'h1014, 0);   push(0, 1, 32'h1, "cnt1");
        drive(1, 0, 32'h1014, 0);   push(0, 1, 32'h2, "cnt2");
        drive(1, 1, 32'h1010, 3);   push(0, 1, 32'h1, "ctrl_pre_match"); push(2, 1, 1, "irq_set_wins");
        drive(1, 0, 32'h1014, 0);   push(0, 1, 32'h0, "cnt_wrapped0"); push(2, 1, 1, "irq_held");
        drive(1, 0, 32'h1010, 0);   push(0, 1, 32'h3, "ctrl_exp_en");
        drive(1, 1, 32'h1010, 3);   push(0, 1, 32'h3, "ctrl_pre_w1c"); push(2, 1, 0, "irq_w1c_clear");
        drive(1, 0, 32'h1010, 0);   push(0, 1, 32'h1, "ctrl_after_w1c");
        drive(1, 1, 32'h1010, 2);

        // Reset mid-operation
        drive(1, 1, 32'h8, 32'hCAFE_F00D);
        drive(1, 1, 32'h1010, 1);
        drive(1, 1, 32'h1000, 32'hFF); push(1, 1, 32'hFF, "gpio_ff");
        drive(0, 1, 32'h8, 32'h77); push(0, 1, 32'h0, "rst2_readdata"); push(2, 1, 0, "rst2_irq");
        push(1, 1, 32'h0, "rst2_gpio_out");
        drive(1, 0, 32'h1004, 0);   push(0, 1, 32'h0, "rst2_gpio_in");
        drive(1, 0, 32'h1008, 0);   push(0, 1, 32'h1, "cycle_a");
        drive(1, 0, 32'h1008, 0);   push(0, 1, 32'h2, "cycle_b");
        drive(1, 0, 32'h1000, 0);   push(0, 1, 32'h0, "rst2_gpio_rd");
        drive(1, 0, 32'h100C, 0);   push(0, 1, 32'h0, "rst2_cmp");
        drive(1, 0, 32'h1010, 0);   push(0, 1, 32'h0, "rst2_ctrl");
        drive(1, 0, 32'h1014, 0);   push(0, 1, 32'h0, "rst2_cnt");
        drive(1, 0, 32'h8, 0);      push(0, 1, 32'hCAFE_F00D, "ram2_kept");

        // Unmapped, no alias at 0x400
        drive(1, 1, 32'h0, 32'h0BAD_0000);
        drive(1, 1, 32'h2000, 32'hDEAD); push(0, 1, 32'h0, "unmapped_2000");
        drive(1, 1, 32'h400, 32'h1111);  push(0, 1, 32'h0, "unmapped_400w");
        drive(1, 0, 32'h400, 0);    push(0, 1, 32'h0, "unmapped_400r");
        drive(1, 0, 32'h0, 0);      push(0, 1, 32'h0BAD_0000, "no_alias_ram0");

        // TIMER_CNT wrap with unreachable CMP
        drive(1, 1, 32'h100C, 5);
        drive(1, 1, 32'h1014, 32'hFFFF_FFFF);
        drive(1, 1, 32'h1010, 1);
        drive(1, 0, 32'h1014, 0);   push(0, 1, 32'hFFFF_FFFF, "cnt_max");
        drive(1, 0, 32'h1014, 0);   push(0, 1, 32'h0, "cnt_wrap0"); push(2, 1, 0, "irq_no_wrap");
        drive(1, 0, 32'h1010, 0);   push(0, 1, 32'h1, "ctrl_no_exp");

        drive(1, 0, 32'h0, 0);
        repeat (4) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
